// File: rtl/serial_pattern_detector_pkg.sv
// Shared types and helpers for the configurable serial pattern detector.
package serial_pattern_detector_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HUNT = 2'd2
    } spd_state_e;

    function automatic int spd_fill_w(int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/spd_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module spd_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/serial_pattern_detector.sv
// Masked serial pattern detector with overlap control.
// Optional saturating match counter under SPD_MATCH_COUNT_EN.
module serial_pattern_detector
    import serial_pattern_detector_pkg::*;
#(
    parameter int PAT_W = 9,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic             cfg_overlap,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             armed,
    output logic             match
`ifdef SPD_MATCH_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_count
`endif
);

    localparam int FW = spd_fill_w(PAT_W);
    localparam logic [FW-1:0] FILL_LAST = FW'(PAT_W - 1);

    spd_state_e       state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] mask_q, mask_d;
    logic             ovl_q, ovl_d;
    logic [PAT_W-1:0] win_q, win_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             match_q, match_d;
    logic [PAT_W-1:0] shifted;
    logic             hit;

    assign shifted = {win_q[PAT_W-2:0], in_bit};
    assign hit     = (((shifted ^ pat_q) & mask_q) == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            mask_q  <= '0;
            ovl_q   <= 1'b0;
            win_q   <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            mask_q  <= mask_d;
            ovl_q   <= ovl_d;
            win_q   <= win_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        mask_d  = mask_q;
        ovl_d   = ovl_q;
        win_d   = win_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        if (cfg_load) begin
            // A beat arriving with a reload is dropped on purpose.
            pat_d   = cfg_pattern;
            mask_d  = cfg_mask;
            ovl_d   = cfg_overlap;
            win_d   = '0;
            fill_d  = '0;
            state_d = FILL;
        end else if (in_valid) begin
            unique case (state_q)
                IDLE: begin
                end
                FILL: begin
                    win_d  = shifted;
                    fill_d = fill_q + 1'b1;
                    if (fill_q == FILL_LAST) begin
                        state_d = HUNT;
                        if (hit) begin
                            match_d = 1'b1;
                            if (!ovl_q) begin
                                fill_d  = '0;
                                state_d = FILL;
                            end
                        end
                    end
                end
                HUNT: begin
                    win_d = shifted;
                    if (hit) begin
                        match_d = 1'b1;
                        if (!ovl_q) begin
                            fill_d  = '0;
                            state_d = FILL;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign match = match_q;
    assign armed = (state_q == HUNT);

`ifdef SPD_MATCH_COUNT_EN
    spd_sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (cfg_load),
        .inc  (match_d),
        .q    (match_count)
    );
`endif

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Directed self-checking bench for serial_pattern_detector.
module tb_serial_pattern_detector;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_load;
    logic [8:0] cfg_pattern;
    logic [8:0] cfg_mask;
    logic       cfg_overlap;
    logic       in_valid;
    logic       in_bit;
    logic       armed;
    logic       match;
    logic       armed2;
    logic       match2;
`ifdef SPD_MATCH_COUNT_EN
    logic [15:0] match_count;
    logic [1:0]  match_count2;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    serial_pattern_detector #(.PAT_W(9), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_mask   (cfg_mask),
        .cfg_overlap(cfg_overlap),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .armed      (armed),
        .match      (match)
`ifdef SPD_MATCH_COUNT_EN
        ,
        .match_count(match_count)
`endif
    );

    serial_pattern_detector #(.PAT_W(9), .CNT_W(2)) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_mask   (cfg_mask),
        .cfg_overlap(cfg_overlap),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .armed      (armed2),
        .match      (match2)
`ifdef SPD_MATCH_COUNT_EN
        ,
        .match_count(match_count2)
`endif
    );

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        cfg_load = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic load(input logic [8:0] p, input logic [8:0] m,
                        input logic o);
        cfg_load = 1'b1;
        cfg_pattern = p;
        cfg_mask = m;
        cfg_overlap = o;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // bits[n-1] is fed first; mv[i]/av[i] sampled after beat i+1
    task automatic feed(input logic [15:0] bits, input int n,
                        output logic [15:0] mv, output logic [15:0] av);
        mv = '0;
        av = '0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_bit = bits[n-1-i];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            mv[i] = match;
            av[i] = armed;
        end
    endtask

    task automatic test_reset();
        logic [15:0] mv, av;
        do_reset();
        total++;
        if (match !== 1'b0 || armed !== 1'b0) begin
            bad++;
            $display("FAIL reset_out got m=%b a=%b exp 0 0", match, armed);
        end
`ifdef SPD_MATCH_COUNT_EN
        total++;
        if (match_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_cnt got=%0d exp=0", match_count);
        end
`endif
        feed(16'h01FF, 12, mv, av);
        total++;
        if (mv !== 16'h0 || av !== 16'h0) begin
            bad++;
            $display("FAIL idle_ignore got mv=%h av=%h exp 0 0", mv, av);
        end
    endtask

    task automatic test_basic();
        logic [15:0] mv, av;
        do_reset();
        load(9'b011001001, 9'h1FF, 1'b0);
        feed(16'h00C9, 9, mv, av);
        total++;
        if (mv !== 16'h0100) begin
            bad++;
            $display("FAIL basic_match got=%h exp=0100", mv);
        end
        total++;
        if (av !== 16'h0) begin
            bad++;
            $display("FAIL basic_armed got=%h exp=0000", av);
        end
`ifdef SPD_MATCH_COUNT_EN
        total++;
        if (match_count !== 16'd1) begin
            bad++;
            $display("FAIL basic_cnt got=%0d exp=1", match_count);
        end
`endif
        idle(1);
        total++;
        if (match !== 1'b0) begin
            bad++;
            $display("FAIL basic_pulse got=%b exp=0", match);
        end
    endtask

    task automatic test_overlap();
        logic [15:0] mv, av;
        load(9'b101010101, 9'h1FF, 1'b1);
        feed(16'h0555, 11, mv, av);
        total++;
        if (mv !== 16'h0500) begin
            bad++;
            $display("FAIL ovl1_match got=%h exp=0500", mv);
        end
        total++;
        if (av !== 16'h0700) begin
            bad++;
            $display("FAIL ovl1_armed got=%h exp=0700", av);
        end
`ifdef SPD_MATCH_COUNT_EN
        total++;
        if (match_count !== 16'd2) begin
            bad++;
            $display("FAIL ovl1_cnt got=%0d exp=2", match_count);
        end
`endif
        load(9'b101010101, 9'h1FF, 1'b0);
        feed(16'h0555, 11, mv, av);
        total++;
        if (mv !== 16'h0100 || av !== 16'h0) begin
            bad++;
            $display("FAIL ovl0_match got mv=%h av=%h exp 0100 0000", mv, av);
        end
    endtask

    task automatic test_gaps();
        logic [15:0] mv1, mv2, av;
        logic        seen;
        load(9'b011001001, 9'h1FF, 1'b0);
        feed(16'h0006, 4, mv1, av);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            seen = seen | match;
        end
        feed(16'h0009, 5, mv2, av);
        total++;
        if (mv1 !== 16'h0 || seen !== 1'b0 || mv2 !== 16'h0010) begin
            bad++;
            $display("FAIL gaps got mv1=%h gap=%b mv2=%h exp 0000 0 0010",
                     mv1, seen, mv2);
        end
    endtask

    task automatic test_mask();
        logic [15:0] mv, av;
        load(9'b011000000, 9'b111100000, 1'b0);
        feed(16'h00DF, 9, mv, av);
        total++;
        if (mv !== 16'h0100) begin
            bad++;
            $display("FAIL mask_s1 got=%h exp=0100", mv);
        end
        feed(16'h00D5, 9, mv, av);
        total++;
        if (mv !== 16'h0100) begin
            bad++;
            $display("FAIL mask_s2 got=%h exp=0100", mv);
        end
        feed(16'h01C0, 9, mv, av);
        total++;
        if (mv !== 16'h0 || av !== 16'h0100) begin
            bad++;
            $display("FAIL mask_s3 got mv=%h av=%h exp 0000 0100", mv, av);
        end
    endtask

    task automatic test_reload();
        logic [15:0] mv, av;
        load(9'b011001001, 9'h1FF, 1'b0);
        feed(16'h00C9, 9, mv, av);
        feed(16'h000C, 5, mv, av);
        load(9'b011001001, 9'h1FF, 1'b0);
`ifdef SPD_MATCH_COUNT_EN
        total++;
        if (match_count !== 16'd0) begin
            bad++;
            $display("FAIL reload_cnt got=%0d exp=0", match_count);
        end
`endif
        feed(16'h0009, 4, mv, av);
        total++;
        if (mv !== 16'h0) begin
            bad++;
            $display("FAIL reload_stale got=%h exp=0000", mv);
        end
        feed(16'h00C9, 9, mv, av);
        total++;
        if (mv !== 16'h0100) begin
            bad++;
            $display("FAIL reload_fresh got=%h exp=0100", mv);
        end
    endtask

    task automatic test_collision();
        logic [15:0] mv, av;
        load(9'b011001001, 9'h1FF, 1'b0);
        feed(16'h0064, 8, mv, av);
        cfg_load = 1'b1;
        in_valid = 1'b1;
        in_bit = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        in_valid = 1'b0;
        total++;
        if (match !== 1'b0) begin
            bad++;
            $display("FAIL collide got=%b exp=0", match);
        end
        feed(16'h00C9, 9, mv, av);
        total++;
        if (mv !== 16'h0100) begin
            bad++;
            $display("FAIL collide_after got=%h exp=0100", mv);
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] mv, av;
        load(9'b011001001, 9'h1FF, 1'b1);
        feed(16'h0032, 7, mv, av);
        do_reset();
        total++;
        if (match !== 1'b0 || armed !== 1'b0) begin
            bad++;
            $display("FAIL midrst_out got m=%b a=%b exp 0 0", match, armed);
        end
        feed(16'h00C9, 9, mv, av);
        feed(16'h00C9, 9, av, av);
        total++;
        if (mv !== 16'h0 || av !== 16'h0) begin
            bad++;
            $display("FAIL midrst_ignore got mv=%h av=%h exp 0 0", mv, av);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] mv, av;
        logic [1:0]  c12;
        c12 = '0;
        load(9'h000, 9'h000, 1'b1);
        feed(16'h0000, 12, mv, av);
`ifdef SPD_MATCH_COUNT_EN
        c12 = match_count2;
`endif
        feed(16'h0000, 3, av, av);
        mv[14:12] = av[2:0];
        total++;
        if (mv !== 16'h7F00) begin
            bad++;
            $display("FAIL b2b_match got=%h exp=7F00", mv);
        end
        total++;
        if (match2 !== 1'b1) begin
            bad++;
            $display("FAIL sat_pulse got=%b exp=1", match2);
        end
`ifdef SPD_MATCH_COUNT_EN
        total++;
        if (match_count !== 16'd7) begin
            bad++;
            $display("FAIL b2b_cnt got=%0d exp=7", match_count);
        end
        total++;
        if (c12 !== 2'd3 || match_count2 !== 2'd3) begin
            bad++;
            $display("FAIL sat_cnt got %0d/%0d exp 3/3", c12, match_count2);
        end
`endif
    endtask

    initial begin
        reset = 1'b0;
        cfg_load = 1'b0;
        cfg_pattern = '0;
        cfg_mask = '0;
        cfg_overlap = 1'b0;
        in_valid = 1'b0;
        in_bit = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_overlap();
        test_gaps();
        test_mask();
        test_reload();
        test_collision();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
